// File: rtl/seq_pkg.sv
// Shared encodings for the sequencer arbiter: controller states and sequencer phases.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    PhFirst  = 2'b11,
    PhSecond = 2'b01,
    PhThird  = 2'b10
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PhFirst:  return PhSecond;
      PhSecond: return PhThird;
      default:  return PhFirst;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin owner of the shared 3-phase sequencer: grants one requester, runs its
// requested passes, and forwards that requester's hold/abort as sequencer pause/restart.
module seq_arbiter
  import seq_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned PASS_W = 4,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*PASS_W-1:0] passes_i,
  input  logic [N_REQ-1:0]        hold_i,
  input  logic [N_REQ-1:0]        abort_i,
  input  logic                    seq_terminal_i,
  output logic                    seq_pause_o,
  output logic                    seq_restart_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    busy_o,
  output logic [PASS_W-1:0]       pass_cnt_o,
  output logic                    done_o,
  output logic [ID_W-1:0]         done_id_o,
  output logic                    aborted_o
);

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [ID_W-1:0]   grant_id_q, done_id_q, ptr_q;
  logic [PASS_W-1:0] pass_cnt_q, target_q;
  logic              busy_q, done_q, aborted_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   pick_idx, ptr_next;
  logic              pick_any;
  logic [PASS_W-1:0] pick_passes, pass_inc;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign pick_passes = passes_i[32'(pick_idx)*PASS_W +: PASS_W];
  assign pass_inc    = pass_cnt_q + PASS_W'(1);
  assign ptr_next    = (grant_id_q == ID_W'(N_REQ-1)) ? '0 : grant_id_q + ID_W'(1);

  // Outside RUN the sequencer is held parked in FIRST.
  always_comb begin
    seq_pause_o   = 1'b0;
    seq_restart_o = 1'b1;
    if (state_q == StRun) begin
      seq_pause_o   = hold_i[grant_id_q] & ~abort_i[grant_id_q];
      seq_restart_o = abort_i[grant_id_q] | ~req_i[grant_id_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      done_id_q  <= '0;
      ptr_q      <= '0;
      pass_cnt_q <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q    <= 1'b0;
          aborted_q <= 1'b0;
          if (pick_any) begin
            state_q    <= StRun;
            grant_q    <= pick_onehot;
            grant_id_q <= pick_idx;
            busy_q     <= 1'b1;
            pass_cnt_q <= '0;
            target_q   <= (pick_passes == '0) ? PASS_W'(1) : pick_passes;
          end
        end
        StRun: begin
          // Restart (abort or req drop) wins over a coincident terminal.
          if (seq_restart_o) begin
            state_q   <= StDone;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            done_id_q <= grant_id_q;
            aborted_q <= 1'b1;
          end else if (seq_terminal_i) begin
            pass_cnt_q <= pass_inc;
            if (pass_inc == target_q) begin
              state_q   <= StDone;
              grant_q   <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              done_id_q <= grant_id_q;
              aborted_q <= 1'b0;
            end
          end
        end
        StDone: begin
          done_q    <= 1'b0;
          aborted_q <= 1'b0;
          ptr_q     <= ptr_next;
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;
  assign pass_cnt_o = pass_cnt_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign aborted_o  = aborted_q;

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter with a behavioural 3-phase sequencer on its pause/restart pins.
module tb_seq_arbiter;
  import seq_pkg::*;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned PASS_W = 4;
  localparam int unsigned ID_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req, hold, abort;
  logic [N_REQ*PASS_W-1:0] passes;
  logic                    seq_terminal, seq_pause, seq_restart;
  logic [N_REQ-1:0]        grant;
  logic [ID_W-1:0]         grant_id, done_id;
  logic                    busy, done, aborted;
  logic [PASS_W-1:0]       pass_cnt;
  phase_e                  ph;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_arbiter #(
    .N_REQ  (N_REQ),
    .PASS_W (PASS_W),
    .ID_W   (ID_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .passes_i       (passes),
    .hold_i         (hold),
    .abort_i        (abort),
    .seq_terminal_i (seq_terminal),
    .seq_pause_o    (seq_pause),
    .seq_restart_o  (seq_restart),
    .grant_o        (grant),
    .grant_id_o     (grant_id),
    .busy_o         (busy),
    .pass_cnt_o     (pass_cnt),
    .done_o         (done),
    .done_id_o      (done_id),
    .aborted_o      (aborted)
  );

  // Sequencer model: restart forces FIRST, pause holds, else FIRST->SECOND->THIRD->FIRST.
  always_ff @(posedge clk) begin
    if (seq_restart) ph <= PhFirst;
    else if (!seq_pause) ph <= next_phase(ph);
  end
  assign seq_terminal = (ph == PhThird);

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    hold   = '0;
    abort  = '0;
    passes = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; hold = '0; abort = '0; passes = '0;
    #12;
    total++; if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (pass_cnt !== 4'd0) $display("FAIL reset_pass_cnt got %0d want 0", pass_cnt); else passed++;
    total++; if (done !== 1'b0 || aborted !== 1'b0) $display("FAIL reset_done got %b%b want 00", done, aborted); else passed++;
    total++; if (seq_restart !== 1'b1 || seq_pause !== 1'b0) $display("FAIL reset_seq got r%b p%b want r1 p0", seq_restart, seq_pause); else passed++;
  endtask

  task automatic test_single();
    int runs = 0;
    int terms = 0;
    do_reset();
    passes[0 +: PASS_W] = 4'd2;
    req = 4'b0001;
    @(negedge clk);
    total++; if (grant !== 4'b0001 || grant_id !== 2'd0) $display("FAIL single_grant got %b/%0d want 0001/0", grant, grant_id); else passed++;
    total++; if (busy !== 1'b1 || pass_cnt !== 4'd0) $display("FAIL single_busy got %b/%0d want 1/0", busy, pass_cnt); else passed++;
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b1) break;
      runs++;
      if (seq_terminal === 1'b1) terms++;
      @(negedge clk);
    end
    total++; if (runs != 6) $display("FAIL single_run_cycles got %0d want 6", runs); else passed++;
    total++; if (terms != 2) $display("FAIL single_terminals got %0d want 2", terms); else passed++;
    total++; if (done !== 1'b1 || done_id !== 2'd0 || aborted !== 1'b0)
      $display("FAIL single_done got d%b id%0d a%b want d1 id0 a0", done, done_id, aborted); else passed++;
    total++; if (pass_cnt !== 4'd2 || grant !== 4'b0000) $display("FAIL single_final got cnt%0d g%b want cnt2 g0000", pass_cnt, grant); else passed++;
    req = '0;
    @(negedge clk);
    total++; if (done !== 1'b0 || pass_cnt !== 4'd2) $display("FAIL single_after got d%b cnt%0d want d0 cnt2", done, pass_cnt); else passed++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [ID_W-1:0] exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) passes[i*PASS_W +: PASS_W] = 4'd1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_id = ID_W'(i % 4);
      wait_done(ok);
      total++;
      if (!ok) $display("FAIL rr_timeout step %0d got no done want done", i);
      else if (done_id !== exp_id || aborted !== 1'b0)
        $display("FAIL rr_order step %0d got id%0d a%b want id%0d a0", i, done_id, aborted, exp_id);
      else passed++;
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold();
    int runs = 0;
    int bad_pause = 0;
    int bad_term = 0;
    do_reset();
    passes[2*PASS_W +: PASS_W] = 4'd1;
    req = 4'b0100;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b1) break;
      runs++;
      hold = (runs >= 2 && runs <= 6) ? 4'b0100 : 4'b0000;
      #1;
      if (runs >= 2 && runs <= 6) begin
        if (seq_pause !== 1'b1 || ph !== PhSecond) bad_pause++;
        if (seq_terminal !== 1'b0 || pass_cnt !== 4'd0) bad_term++;
      end
      @(negedge clk);
    end
    hold = '0;
    total++; if (bad_pause != 0) $display("FAIL hold_pause got %0d bad cycles want 0", bad_pause); else passed++;
    total++; if (bad_term != 0) $display("FAIL hold_no_term got %0d bad cycles want 0", bad_term); else passed++;
    total++; if (runs != 8) $display("FAIL hold_run_cycles got %0d want 8", runs); else passed++;
    total++; if (done !== 1'b1 || done_id !== 2'd2 || aborted !== 1'b0 || pass_cnt !== 4'd1)
      $display("FAIL hold_done got d%b id%0d a%b cnt%0d want d1 id2 a0 cnt1", done, done_id, aborted, pass_cnt); else passed++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_abort_terminal();
    do_reset();
    passes[1*PASS_W +: PASS_W] = 4'd3;
    req = 4'b0010;
    repeat (3) @(negedge clk);
    abort = 4'b0010;
    #1;
    total++; if (seq_terminal !== 1'b1 || seq_restart !== 1'b1 || busy !== 1'b1)
      $display("FAIL abort_same_cycle got t%b r%b b%b want t1 r1 b1", seq_terminal, seq_restart, busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1 || aborted !== 1'b1 || done_id !== 2'd1)
      $display("FAIL abort_done got d%b a%b id%0d want d1 a1 id1", done, aborted, done_id); else passed++;
    total++; if (pass_cnt !== 4'd0) $display("FAIL abort_pass_cnt got %0d want 0", pass_cnt); else passed++;
    abort = '0;
    req   = '0;
    @(negedge clk);
  endtask

  task automatic test_zero_passes();
    do_reset();
    passes[3*PASS_W +: PASS_W] = 4'd0;
    req = 4'b1000;
    repeat (4) @(negedge clk);
    total++; if (done !== 1'b1 || done_id !== 2'd3 || aborted !== 1'b0 || pass_cnt !== 4'd1)
      $display("FAIL zero_passes got d%b id%0d a%b cnt%0d want d1 id3 a0 cnt1", done, done_id, aborted, pass_cnt); else passed++;
    passes[3*PASS_W +: PASS_W] = 4'd2;
    @(negedge clk);
    total++; if (busy !== 1'b0 || grant !== 4'b0000 || done !== 1'b0)
      $display("FAIL zero_idle_gap got b%b g%b d%b want b0 g0000 d0", busy, grant, done); else passed++;
    @(negedge clk);
    total++; if (grant !== 4'b1000 || busy !== 1'b1) $display("FAIL zero_regrant got g%b b%b want g1000 b1", grant, busy); else passed++;
    @(negedge clk);
    req = 4'b0000;
    #1;
    total++; if (seq_restart !== 1'b1) $display("FAIL drop_restart got %b want 1", seq_restart); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1 || aborted !== 1'b1 || done_id !== 2'd3 || pass_cnt !== 4'd0)
      $display("FAIL drop_done got d%b a%b id%0d cnt%0d want d1 a1 id3 cnt0", done, aborted, done_id, pass_cnt); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    passes[0 +: PASS_W] = 4'd3;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    total++; if (pass_cnt !== 4'd1 || busy !== 1'b1) $display("FAIL midrun_pre got cnt%0d b%b want cnt1 b1", pass_cnt, busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 4'b0000 || busy !== 1'b0 || pass_cnt !== 4'd0 || seq_restart !== 1'b1)
      $display("FAIL midrun_reset got g%b b%b cnt%0d r%b want g0000 b0 cnt0 r1", grant, busy, pass_cnt, seq_restart); else passed++;
    for (int i = 0; i < 4; i++) passes[i*PASS_W +: PASS_W] = 4'd1;
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (grant !== 4'b0010 || grant_id !== 2'd1) $display("FAIL midrun_regrant got g%b id%0d want g0010 id1", grant, grant_id); else passed++;
    req = '0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_abort_terminal();
    test_zero_passes();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_arbiter.md
Name: seq_arbiter

Overview:
Controller and arbiter for the shared 3-phase sequencer (states FIRST→SECOND→THIRD, inputs pause/restart, output terminal). It grants the sequencer to one of N_REQ requesters at a time, round-robin. It runs the requested number of complete passes for the granted requester, forwarding that requester's hold/abort as pause/restart. It sits beside the sequencer and drives the sequencer's pause/restart pins directly.

Parameters:
N_REQ, 4, number of requesters (2..8)
PASS_W, 4, width of per-requester pass count
ID_W, 2, grant index width = clog2(N_REQ)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester request, level; held until done
passes  in  N_REQ*PASS_W  pass count per requester, slice i = [i*PASS_W +: PASS_W]; sampled at grant
hold  in  N_REQ  per-requester pause request
abort  in  N_REQ  per-requester abort
seq_terminal  in  1  sequencer terminal output
seq_pause  out  1  to sequencer pause
seq_restart  out  1  to sequencer restart
grant  out  N_REQ  one-hot grant, registered
grant_id  out  ID_W  index of granted requester, registered
busy  out  1  high in RUN
pass_cnt  out  PASS_W  completed passes of current grant
done  out  1  one-cycle pulse at end of grant
done_id  out  ID_W  requester finished; valid with done
aborted  out  1  with done: grant ended by abort or req drop

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, grant_id=0, busy=0, pass_cnt=0, done=0, done_id=0, aborted=0, rr pointer=0 (requester 0 highest priority).
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - seq_restart=1, seq_pause=0, which parks the sequencer in FIRST.
  - If any req is high, pick the first set bit searching from the rr pointer upward, with wrap.
  - Latch target=passes slice; target 0 is treated as 1.
  - Next cycle: state=RUN, grant/grant_id set, busy=1, pass_cnt=0.
  - Latency req→grant: 1 cycle when idle.
- RUN:
  - seq_pause=hold[grant_id] & ~abort[grant_id], combinational.
  - seq_restart=abort[grant_id] | ~req[grant_id], combinational.
  - Pass completion: seq_terminal=1 and seq_restart=0 increments pass_cnt.
  - If pass_cnt+1==target, go to DONE with aborted=0.
  - If seq_restart=1, go to DONE with aborted=1 and do not count the pass. Abort wins over a simultaneous terminal.
  - Hold may be asserted indefinitely; the grant is not preempted.
- DONE (1 cycle):
  - done=1, done_id=grant_id, grant=0, busy=0.
  - seq_restart=1, seq_pause=0.
  - rr pointer=grant_id+1 (mod N_REQ).
  - Next state IDLE. pass_cnt keeps its final value until the next grant.
- Re-arbitration: DONE→IDLE→RUN, so there are at least 2 idle cycles between grants. A requester still asserting req after done rejoins at lowest priority.
- req/passes/hold/abort of non-granted requesters are ignored outside IDLE arbitration.
- pass_cnt arithmetic is modulo 2^PASS_W. target ≤ 2^PASS_W−1, so wrap cannot occur before completion.
- Reset mid-RUN: all outputs return to reset values immediately. seq_restart goes to 1 combinationally (IDLE), so the sequencer is forced to FIRST on its next edge.
- Illegal state encoding: go to IDLE.

Decomposition:
- Shared package seq_pkg: state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10. Sequencer phase encodings FIRST=2'b11, SECOND=2'b01, THIRD=2'b10 for bench models.
- One sub-module: rr_pick — combinational round-robin selector. Inputs: req vector and pointer. Outputs: one-hot, index, any.

Test Plan:
- Single request: req=4'b0001, passes[0]=2, no hold → grant=0001 one cycle after req. Exactly 2 seq_terminal pulses counted, pass_cnt=2. done=1 with done_id=0, aborted=0. Total 6 RUN cycles.
- Round-robin: req=4'b1111, all passes=1 → done_id sequence 0,1,2,3,0; no requester granted twice before others.
- Hold: grant to 2, hold[2]=1 for 5 cycles in SECOND → seq_pause=1 for those 5 cycles, no terminal, pass_cnt unchanged. RUN lasts 3+5 cycles for passes=1.
- Abort coinciding with terminal: abort[1]=1 in the same cycle as seq_terminal → pass_cnt not incremented, done with aborted=1, seq_restart=1 that cycle.
- passes=0 on requester 3 → runs exactly 1 pass; req[3] dropped mid-pass → aborted=1.
- Reset asserted mid-RUN with pass_cnt=1 → grant=0, busy=0, pass_cnt=0, seq_restart=1 immediately. After release, req=4'b0110 grants requester 1 first.
